// File: rtl/dev_dumper_if.sv
// Port bundle for dev_dumper: start request, RAM read port, TX pipe push port
// and a debug view of the FSM state.
interface dev_dumper_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_data;
  logic [7:0]        tx_data;
  logic              tx_push;
  logic              tx_full;
  logic [3:0]        dbg_state;

  // Handshakes:
  // - TX: a character moves only in a cycle where tx_push=1. tx_push is raised
  //   only while tx_full=0, and never in two consecutive cycles.
  // - RAM: ram_rd=1 for one cycle with ram_addr. ram_data must be valid in the
  //   following cycle only.
  // - start is looked at only while the dumper is idle.
  modport master (
    input  start, start_addr, len, ram_data, tx_full,
    output busy, done, ram_addr, ram_rd, tx_data, tx_push, dbg_state
  );
  modport slave (
    output start, start_addr, len, ram_data, tx_full,
    input  busy, done, ram_addr, ram_rd, tx_data, tx_push, dbg_state
  );
endinterface

// File: rtl/dev_dumper.sv
// RAM-to-serial hex dumper: streams a byte range as uppercase hex text lines.
// Optional macro DEV_DUMPER_ADDR_PREFIX_EN prefixes each line with "ADDR: ".
module dev_dumper #(
  parameter int ADDR_W         = 16,
  parameter int BYTES_PER_LINE = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  dev_dumper_if.master  bus
);
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
  localparam int NDIG = (ADDR_W + 3) / 4;
`endif

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_WAIT   = 4'd2,
    S_HI     = 4'd3,
    S_LO     = 4'd4,
    S_SP     = 4'd5,
    S_CR     = 4'd6,
    S_LF     = 4'd7,
    S_FINISH = 4'd8
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
    ,
    S_PHEX   = 4'd9,
    S_PCOLON = 4'd10,
    S_PSP    = 4'd11
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [7:0]        line_q, line_d;
  logic [7:0]        data_q, data_d;
  logic              push_prev_q, push_prev_d;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
  logic [7:0]        nib_q, nib_d;
  logic [4*NDIG-1:0] addr_pad;
  logic [3:0]        pfx_digit;
`endif

  logic       emit_w;
  logic [7:0] char_w;
  logic       push_w;
  logic       can_push;
  logic       line_end;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // A character may leave only when the pipe has room and we did not push last cycle.
  assign can_push = !bus.tx_full && !push_prev_q;
  assign push_w   = emit_w && can_push;
  assign line_end = (rem_q == '0) || (line_q == 8'(BYTES_PER_LINE));

`ifdef DEV_DUMPER_ADDR_PREFIX_EN
  assign addr_pad  = (4*NDIG)'(addr_q);
  assign pfx_digit = 4'(addr_pad >> (4 * nib_q));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      line_q      <= '0;
      data_q      <= '0;
      push_prev_q <= 1'b0;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
      nib_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      line_q      <= line_d;
      data_q      <= data_d;
      push_prev_q <= push_prev_d;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
      nib_q       <= nib_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    line_d      = line_q;
    data_d      = data_q;
    push_prev_d = push_w;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
    nib_d       = nib_q;
`endif
    case (state_q)
      S_IDLE: if (bus.start) begin
        addr_d = bus.start_addr;
        rem_d  = bus.len;
        line_d = '0;
        if (bus.len == '0) begin
          state_d = S_FINISH;
        end else begin
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
          state_d = S_PHEX;
          nib_d   = 8'(NDIG - 1);
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_FETCH: begin
        addr_d  = addr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        line_d  = line_q + 8'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        data_d  = bus.ram_data;
        state_d = S_HI;
      end
      S_HI: if (push_w) state_d = S_LO;
      S_LO: if (push_w) state_d = line_end ? S_CR : S_SP;
      S_SP: if (push_w) state_d = S_FETCH;
      S_CR: if (push_w) state_d = S_LF;
      S_LF: if (push_w) begin
        line_d = '0;
        if (rem_q == '0) begin
          state_d = S_FINISH;
        end else begin
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
          state_d = S_PHEX;
          nib_d   = 8'(NDIG - 1);
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_FINISH: state_d = S_IDLE;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
      S_PHEX: if (push_w) begin
        if (nib_q == 8'd0) state_d = S_PCOLON;
        else               nib_d   = nib_q - 8'd1;
      end
      S_PCOLON: if (push_w) state_d = S_PSP;
      S_PSP:    if (push_w) state_d = S_FETCH;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    emit_w       = 1'b0;
    char_w       = 8'h00;
    bus.ram_rd   = 1'b0;
    bus.ram_addr = '0;
    bus.done     = 1'b0;
    bus.busy     = (state_q != S_IDLE) && (state_q != S_FINISH);
    case (state_q)
      S_FETCH: begin
        bus.ram_rd   = 1'b1;
        bus.ram_addr = addr_q;
      end
      S_HI:     begin emit_w = 1'b1; char_w = hex_char(data_q[7:4]); end
      S_LO:     begin emit_w = 1'b1; char_w = hex_char(data_q[3:0]); end
      S_SP:     begin emit_w = 1'b1; char_w = 8'h20; end
      S_CR:     begin emit_w = 1'b1; char_w = 8'h0D; end
      S_LF:     begin emit_w = 1'b1; char_w = 8'h0A; end
      S_FINISH: bus.done = 1'b1;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
      S_PHEX:   begin emit_w = 1'b1; char_w = hex_char(pfx_digit); end
      S_PCOLON: begin emit_w = 1'b1; char_w = 8'h3A; end
      S_PSP:    begin emit_w = 1'b1; char_w = 8'h20; end
`endif
      default: ;
    endcase
    bus.tx_data   = char_w;
    bus.tx_push   = push_w;
    bus.dbg_state = state_q;
  end
endmodule

// File: tb/tb_dev_dumper.sv
// Self-checking bench for dev_dumper: a text-level model builds the expected
// character and read-address streams; a negedge monitor compares against them.
module tb_dev_dumper;
  localparam int ADDR_W = 16;
  localparam int BPL    = 4;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dev_dumper_if #(.ADDR_W(ADDR_W)) bus();
  dev_dumper #(.ADDR_W(ADDR_W), .BYTES_PER_LINE(BPL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [7:0]  mem [0:65535];
  logic [7:0]  exp_q[$];
  logic [15:0] exp_rd_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int chars_seen = 0;
  int stall_mode = 0;
  int hold_cnt = 0;
  logic prev_push = 1'b0;
  string hexs = "0123456789ABCDEF";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected none", name, act);
  endtask

  // RAM: data valid only in the cycle after the strobe, garbage otherwise
  always @(posedge clk)
    bus.ram_data <= bus.ram_rd ? mem[bus.ram_addr] : 8'($urandom);

  // TX pipe back-pressure driver
  initial begin
    bus.tx_full = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (stall_mode)
        1: bus.tx_full = ($urandom_range(0, 2) == 0);
        2: if (chars_seen >= 3 && hold_cnt < 100) begin
             bus.tx_full = 1'b1;
             hold_cnt++;
           end else begin
             bus.tx_full = 1'b0;
           end
        default: bus.tx_full = 1'b0;
      endcase
    end
  end

  // scoreboard / compare process
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_push <= 1'b0;
    end else begin
      if (bus.tx_push) begin
        check("push_while_full", bus.tx_full, 1'b0);
        check("push_adjacent", prev_push, 1'b0);
        if (exp_q.size() == 0) fail("extra_push", bus.tx_data);
        else check("tx_data", bus.tx_data, exp_q.pop_front());
        chars_seen++;
      end
      if (bus.ram_rd) begin
        if (exp_rd_q.size() == 0) fail("extra_ram_rd", bus.ram_addr);
        else check("ram_addr", bus.ram_addr, exp_rd_q.pop_front());
      end
      if (bus.done) begin
        done_cnt++;
        check("busy_during_done", bus.busy, 1'b0);
      end
      prev_push <= bus.tx_push;
    end
  end

  // Text-level model: what the host should see for a dump of n bytes from a.
  task automatic build_model(input logic [15:0] a, input logic [15:0] n);
    int col;
    logic [15:0] p;
    logic [7:0] b;
    exp_q.delete();
    exp_rd_q.delete();
    col = 0;
    p = a;
    for (int i = 0; i < int'(n); i++) begin
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
      if (col == 0) begin
        for (int k = 3; k >= 0; k--) exp_q.push_back(hexs[int'((p >> (4*k)) & 16'hF)]);
        exp_q.push_back(8'h3A);
        exp_q.push_back(8'h20);
      end
`endif
      b = mem[p];
      exp_rd_q.push_back(p);
      exp_q.push_back(hexs[int'(b / 16)]);
      exp_q.push_back(hexs[int'(b % 16)]);
      col++;
      if (i == int'(n) - 1 || col == BPL) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        col = 0;
      end else begin
        exp_q.push_back(8'h20);
      end
      p = p + 16'd1;
    end
  endtask

  // hand-written expected text pins the model
  task automatic pin(input string s);
    check("model_len", exp_q.size(), s.len());
    for (int i = 0; i < s.len() && i < exp_q.size(); i++)
      check("model_char", exp_q[i], s[i]);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, bus.busy, 1'b0);
    check({name, "_done"}, bus.done, 1'b0);
    check({name, "_ram_rd"}, bus.ram_rd, 1'b0);
    check({name, "_ram_addr"}, bus.ram_addr, 16'h0);
    check({name, "_tx_push"}, bus.tx_push, 1'b0);
    check({name, "_tx_data"}, bus.tx_data, 8'h0);
    check({name, "_state"}, bus.dbg_state, 4'd0);
  endtask

  task automatic pulse_start(input logic [15:0] a, input logic [15:0] n);
    @(posedge clk); #2;
    bus.start = 1'b1; bus.start_addr = a; bus.len = n;
    @(posedge clk); #2;
    bus.start = 1'b0; bus.start_addr = 16'($urandom); bus.len = 16'($urandom);
  endtask

  // driver: run one dump whose model is already in exp_q / exp_rd_q
  task automatic run_dump(input logic [15:0] a, input logic [15:0] n,
                          input int mode, input bit extra_start);
    int d0;
    int waited;
    stall_mode = mode; hold_cnt = 0; chars_seen = 0;
    d0 = done_cnt;
    pulse_start(a, n);
    @(negedge clk);
    check("busy_after_start", bus.busy, (n != 0));
    check("first_rd_latency", bus.ram_rd, (n != 0));
    check("len0_done_latency", bus.done, (n == 0));
    if (mode == 0 && n != 0) begin
      @(negedge clk);
      @(negedge clk);
      check("first_push_latency", bus.tx_push, 1'b1);
    end
    if (extra_start) begin
      repeat (7) @(posedge clk);
      #2; bus.start = 1'b1; bus.start_addr = 16'h1234; bus.len = 16'd5;
      @(posedge clk); #2; bus.start = 1'b0;
    end
    waited = 0;
    while (done_cnt == d0 && waited < 5000) begin
      @(posedge clk);
      waited++;
    end
    if (done_cnt == d0) fail("done_timeout", waited);
    repeat (3) @(negedge clk);
    check("busy_after_done", bus.busy, 1'b0);
    check("done_once", done_cnt - d0, 1);
    check("chars_left", exp_q.size(), 0);
    check("reads_left", exp_rd_q.size(), 0);
    stall_mode = 0;
  endtask

  initial begin
    bus.start = 1'b0; bus.start_addr = '0; bus.len = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    #1 rst_n = 1'b1;

    // scenario 1
    mem[16'h0010] = 8'hDE; mem[16'h0011] = 8'hAD; mem[16'h0012] = 8'h0F;
    build_model(16'h0010, 16'd3);
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
    pin("0010: DE AD 0F\015\012");
`else
    pin("DE AD 0F\015\012");
`endif
    run_dump(16'h0010, 16'd3, 0, 1'b0);

    // scenario 2: line wrap at 4 bytes
    for (int i = 0; i < 5; i++) mem[i] = 8'(i);
    build_model(16'h0000, 16'd5);
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
    pin("0000: 00 01 02 03\015\0120004: 04\015\012");
`else
    pin("00 01 02 03\015\01204\015\012");
`endif
    run_dump(16'h0000, 16'd5, 0, 1'b0);

    // scenario 3: long back-pressure plus ignored start while busy
    build_model(16'h0010, 16'd3);
    run_dump(16'h0010, 16'd3, 2, 1'b1);

    // scenario 4: address wrap, then empty range
    mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hA5;
    build_model(16'hFFFF, 16'd2);
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
    pin("FFFF: 5A A5\015\012");
`else
    pin("5A A5\015\012");
`endif
    run_dump(16'hFFFF, 16'd2, 0, 1'b0);
    build_model(16'h4000, 16'd0);
    check("len0_model_empty", exp_q.size(), 0);
    run_dump(16'h4000, 16'd0, 0, 1'b0);

    // scenario 6 data (prefix crossing 0x0100)
    mem[16'h00FE] = 8'h11; mem[16'h00FF] = 8'h22; mem[16'h0100] = 8'h33;
    build_model(16'h00FE, 16'd3);
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
    pin("00FE: 11 22 33\015\012");
`else
    pin("11 22 33\015\012");
`endif
    run_dump(16'h00FE, 16'd3, 1, 1'b0);

    // scenario 5: reset mid-dump
    begin
      int d0;
      int waited;
      build_model(16'h0200, 16'd10);
      stall_mode = 0; chars_seen = 0;
      d0 = done_cnt;
      pulse_start(16'h0200, 16'd10);
      waited = 0;
      while (chars_seen < 4 && waited < 1000) begin
        @(posedge clk);
        waited++;
      end
      if (chars_seen < 4) fail("reset_wait_timeout", chars_seen);
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_idle_outputs("midreset");
      #1 rst_n = 1'b1;
      exp_q.delete();
      exp_rd_q.delete();
      repeat (10) @(negedge clk);
      check("no_done_on_reset", done_cnt, d0);
      check("idle_after_reset", bus.dbg_state, 4'd0);
    end
    build_model(16'h0300, 16'd6);
    run_dump(16'h0300, 16'd6, 0, 1'b0);

    // randomized dumps
    for (int r = 0; r < 10; r++) begin
      logic [15:0] a;
      logic [15:0] n;
      a = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
      n = 16'($urandom_range(0, 20));
      build_model(a, n);
      run_dump(a, n, int'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    fail("global_timeout", 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
